checkpoint_respawn: RTL and testbench

Player-side responder to the campfire collision detector. Consumes the campfire-touch level, latches the most recently touched campfire as the active checkpoint, and on a player-death pulse runs a freeze / fade-out / respawn-handshake / fade-in sequence that returns the player to that checkpoint. Sits between the campfire collision logic, the player movement controller (which takes `respawn_pos` and the freeze flag) and the renderer (which takes `fade_level`).

---
 rtl/slime_pkg.sv | 27 ++
 rtl/fade_sequencer.sv | 46 ++++
 rtl/checkpoint_respawn.sv | 118 +++++++++++
 tb/tb_checkpoint_respawn.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slime_pkg.sv
// Shared types and position packing helpers for the player-side slime logic.
// Positions travel as a single {x, y} word, matching playerPos.
package slime_pkg;

    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_DYING   = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_FADE_IN = 2'd3
    } state_e;

    function automatic logic [2*POS_W-1:0] pack_pos(input logic [POS_W-1:0] x,
                                                    input logic [POS_W-1:0] y);
        return {x, y};
    endfunction

    function automatic logic [POS_W-1:0] pos_x(input logic [2*POS_W-1:0] p);
        return p[2*POS_W-1:POS_W];
    endfunction

    function automatic logic [POS_W-1:0] pos_y(input logic [2*POS_W-1:0] p);
        return p[POS_W-1:0];
    endfunction

endpackage

// File: rtl/fade_sequencer.sv
// Frame-paced fade stepper: counts frame ticks and moves fade_level one step
// per FRAMES_PER_STEP ticks, up (dir=0) or down (dir=1), holding at the limit.
module fade_sequencer #(
    parameter int FRAMES_PER_STEP = 2,
    parameter int FADE_MAX        = 15
) (
    input  logic       sim_clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic       dir,
    input  logic       frame_tick,
    output logic [3:0] fade_level,
    output logic       at_limit,
    output logic       step_done
);

    localparam int            CW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]    LVL_MAX  = 4'(FADE_MAX);

    logic [CW-1:0] frame_cnt;

    assign at_limit  = dir ? (fade_level == 4'd0) : (fade_level == LVL_MAX);
    assign step_done = enable && frame_tick && (frame_cnt == CNT_LAST);

    // A step at the limit leaves the level alone; the owner uses step_done &&
    // at_limit as its "sequence finished" event.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            frame_cnt  <= '0;
            fade_level <= '0;
        end else if (clear) begin
            frame_cnt  <= '0;
        end else if (enable && frame_tick) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt <= '0;
                if (!at_limit)
                    fade_level <= dir ? fade_level - 4'd1 : fade_level + 4'd1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/checkpoint_respawn.sv
// Latches the last touched campfire as checkpoint and runs the death sequence:
// freeze, fade out, respawn handshake with the player controller, fade in.
module checkpoint_respawn
    import slime_pkg::*;
#(
    parameter int START_X         = 32,
    parameter int START_Y         = 400,
    parameter int SPAWN_DY        = 16,
    parameter int FRAMES_PER_STEP = 2,
    parameter int FADE_MAX        = 15
) (
    input  logic                 sim_clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 campfire_hit,
    input  logic [2:0]           campfire_id,
    input  logic [POS_W-1:0]     campfire_x,
    input  logic [POS_W-1:0]     campfire_y,
    input  logic                 player_dead,
    input  logic                 player_ack,
    output logic                 respawn_req,
    output logic [2*POS_W-1:0]   respawn_pos,
    output logic [2:0]           checkpoint_id,
    output logic                 checkpoint_valid,
    output logic [3:0]           activations,
    output logic                 player_freeze,
    output logic [3:0]           fade_level
);

    state_e           state;
    logic             hit_q;
    logic             hit_rise;
    logic [POS_W:0]   y_diff;
    logic [POS_W-1:0] spawn_y;
    logic             fade_enable;
    logic             fade_dir;
    logic             fade_clear;
    logic             at_limit;
    logic             step_done;

    assign hit_rise = campfire_hit && !hit_q;

    // 11-bit subtraction; a borrow into the top bit means the result went
    // negative and the spawn point clamps to the top of the screen.
    assign y_diff  = {1'b0, campfire_y} - (POS_W+1)'(SPAWN_DY);
    assign spawn_y = y_diff[POS_W] ? '0 : y_diff[POS_W-1:0];

    assign fade_enable = (state == ST_DYING) || (state == ST_FADE_IN);
    assign fade_dir    = (state == ST_FADE_IN);
    assign fade_clear  = (state == ST_ALIVE) && player_dead;

    fade_sequencer #(
        .FRAMES_PER_STEP (FRAMES_PER_STEP),
        .FADE_MAX        (FADE_MAX)
    ) u_fade (
        .sim_clk    (sim_clk),
        .reset      (reset),
        .clear      (fade_clear),
        .enable     (fade_enable),
        .dir        (fade_dir),
        .frame_tick (frame_tick),
        .fade_level (fade_level),
        .at_limit   (at_limit),
        .step_done  (step_done)
    );

    // hit_q tracks the level in every state so a hit held across the death
    // sequence is not mistaken for a fresh touch on return to ALIVE.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state            <= ST_ALIVE;
            hit_q            <= 1'b0;
            respawn_req      <= 1'b0;
            respawn_pos      <= pack_pos(POS_W'(START_X), POS_W'(START_Y));
            checkpoint_id    <= '0;
            checkpoint_valid <= 1'b0;
            activations      <= '0;
            player_freeze    <= 1'b0;
        end else begin
            hit_q <= campfire_hit;
            case (state)
                ST_ALIVE: begin
                    if (hit_rise) begin
                        checkpoint_id    <= campfire_id;
                        respawn_pos      <= pack_pos(campfire_x, spawn_y);
                        checkpoint_valid <= 1'b1;
                        if (activations != 4'd15)
                            activations <= activations + 4'd1;
                    end
                    if (player_dead) begin
                        state         <= ST_DYING;
                        player_freeze <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (step_done && at_limit) begin
                        state       <= ST_RESPAWN;
                        respawn_req <= 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    if (player_ack && respawn_req) begin
                        state       <= ST_FADE_IN;
                        respawn_req <= 1'b0;
                    end
                end
                ST_FADE_IN: begin
                    if (step_done && at_limit) begin
                        state         <= ST_ALIVE;
                        player_freeze <= 1'b0;
                    end
                end
                default: state <= ST_ALIVE;
            endcase
        end
    end

endmodule

// File: tb/tb_checkpoint_respawn.sv
// Randomized bench for checkpoint_respawn: a tick-counting reference model
// queues the expected outputs per cycle and a monitor compares them.
module tb_checkpoint_respawn;

    localparam int START_X  = 32;
    localparam int START_Y  = 400;
    localparam int SPAWN_DY = 16;
    localparam int FPS      = 2;
    localparam int FADE_MAX = 15;
    localparam int TOTAL    = (FADE_MAX + 1) * FPS;

    localparam int P_ALIVE = 0, P_DYING = 1, P_RESPAWN = 2, P_FADE_IN = 3;

    logic        sim_clk = 1'b0;
    logic        reset, frame_tick, campfire_hit, player_dead, player_ack;
    logic [2:0]  campfire_id;
    logic [9:0]  campfire_x, campfire_y;
    logic        respawn_req, checkpoint_valid, player_freeze;
    logic [19:0] respawn_pos;
    logic [2:0]  checkpoint_id;
    logic [3:0]  activations, fade_level;

    always #5 sim_clk = ~sim_clk;

    checkpoint_respawn #(
        .START_X(START_X), .START_Y(START_Y), .SPAWN_DY(SPAWN_DY),
        .FRAMES_PER_STEP(FPS), .FADE_MAX(FADE_MAX)
    ) dut (
        .sim_clk(sim_clk), .reset(reset), .frame_tick(frame_tick),
        .campfire_hit(campfire_hit), .campfire_id(campfire_id),
        .campfire_x(campfire_x), .campfire_y(campfire_y),
        .player_dead(player_dead), .player_ack(player_ack),
        .respawn_req(respawn_req), .respawn_pos(respawn_pos),
        .checkpoint_id(checkpoint_id), .checkpoint_valid(checkpoint_valid),
        .activations(activations), .player_freeze(player_freeze),
        .fade_level(fade_level)
    );

    typedef struct {
        logic        req;
        logic [19:0] pos;
        logic [2:0]  id;
        logic        valid;
        logic [3:0]  acts;
        logic        freeze;
        logic [3:0]  fade;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: phase plus ticks elapsed within the current fade.
    int m_phase, m_ticks, m_id, m_x, m_y, m_acts;
    bit m_valid, m_prev_hit;

    task automatic model_reset();
        m_phase = P_ALIVE; m_ticks = 0; m_id = 0; m_x = START_X; m_y = START_Y;
        m_acts = 0; m_valid = 0; m_prev_hit = 0;
    endtask

    task automatic model_step();
        bit rise;
        if (reset) begin
            model_reset();
            return;
        end
        rise = campfire_hit && !m_prev_hit;
        m_prev_hit = campfire_hit;
        case (m_phase)
            P_ALIVE: begin
                if (rise) begin
                    m_id    = campfire_id;
                    m_x     = campfire_x;
                    m_y     = (campfire_y < SPAWN_DY) ? 0 : campfire_y - SPAWN_DY;
                    m_valid = 1;
                    if (m_acts < 15) m_acts++;
                end
                if (player_dead) begin m_phase = P_DYING; m_ticks = 0; end
            end
            P_DYING: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == TOTAL) m_phase = P_RESPAWN;
            end
            P_RESPAWN: if (player_ack) begin m_phase = P_FADE_IN; m_ticks = 0; end
            default: if (frame_tick) begin
                m_ticks++;
                if (m_ticks == TOTAL) m_phase = P_ALIVE;
            end
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.req    = (m_phase == P_RESPAWN);
        e.freeze = (m_phase != P_ALIVE);
        e.pos    = {m_x[9:0], m_y[9:0]};
        e.id     = m_id[2:0];
        e.valid  = m_valid;
        e.acts   = m_acts[3:0];
        case (m_phase)
            P_ALIVE:   e.fade = 4'd0;
            P_DYING:   e.fade = 4'(m_ticks / FPS);
            P_RESPAWN: e.fade = 4'(FADE_MAX);
            default:   e.fade = 4'(FADE_MAX - m_ticks / FPS);
        endcase
        return e;
    endfunction

    task automatic step();
        model_step();
        q.push_back(model_out());
        @(negedge sim_clk);
        cycle++;
    endtask

    // Runs with random frame ticks until the model reaches phase ph; with
    // noise on, deaths and campfire id 5 touches are thrown in along the way.
    task automatic run_to_phase(input int ph, input bit noise);
        int n = 0;
        while (m_phase != ph && n < 2000) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            if (noise) begin
                player_dead  = ($urandom_range(0, 7) == 0);
                campfire_hit = ($urandom_range(0, 3) == 0);
                campfire_id  = 3'd5;
                campfire_x   = 10'd900;
                campfire_y   = 10'd100;
            end
            step();
            n++;
        end
        frame_tick = 0; player_dead = 0; campfire_hit = 0;
        if (m_phase != ph) begin
            checks++; errors++;
            $display("FAIL run_to_phase: phase %0d not reached, stuck in %0d", ph, m_phase);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge sim_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (respawn_req !== e.req || respawn_pos !== e.pos || checkpoint_id !== e.id ||
                    checkpoint_valid !== e.valid || activations !== e.acts ||
                    player_freeze !== e.freeze || fade_level !== e.fade) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got req=%0b pos=(%0d,%0d) id=%0d valid=%0b acts=%0d freeze=%0b fade=%0d want req=%0b pos=(%0d,%0d) id=%0d valid=%0b acts=%0d freeze=%0b fade=%0d",
                             cycle, respawn_req, respawn_pos[19:10], respawn_pos[9:0], checkpoint_id,
                             checkpoint_valid, activations, player_freeze, fade_level,
                             e.req, e.pos[19:10], e.pos[9:0], e.id, e.valid, e.acts, e.freeze, e.fade);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        model_reset();
        reset = 1; frame_tick = 0; campfire_hit = 0; player_dead = 0; player_ack = 0;
        campfire_id = 0; campfire_x = 0; campfire_y = 0;
        @(negedge sim_clk);
        step(); step();
        reset = 0;
        repeat (3) step();

        // held touch of campfire 3 captures once
        campfire_id = 3; campfire_x = 200; campfire_y = 300; campfire_hit = 1;
        repeat (10) step();
        campfire_hit = 0; step();

        // spawn y clamps at the top edge
        campfire_id = 1; campfire_x = 77; campfire_y = 5; campfire_hit = 1;
        step(); campfire_hit = 0; step();

        // saturation of the activation counter
        for (int i = 0; i < 16; i++) begin
            campfire_id = 3'($urandom); campfire_x = 10'($urandom); campfire_y = 10'($urandom);
            campfire_hit = 1;
            repeat (1 + $urandom_range(0, 2)) step();
            campfire_hit = 0;
            repeat (1 + $urandom_range(0, 2)) step();
        end

        // death with noise, long wait for ack, then fade back in
        player_dead = 1; step(); player_dead = 0;
        run_to_phase(P_RESPAWN, 1);
        for (int i = 0; i < 100; i++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            step();
        end
        frame_tick = 0; player_ack = 1; step(); player_ack = 0;
        run_to_phase(P_ALIVE, 1);
        repeat (3) step();

        // same-cycle touch and death: new checkpoint is the respawn point
        campfire_id = 2; campfire_x = 123; campfire_y = 456; campfire_hit = 1; player_dead = 1;
        step();
        campfire_hit = 0; player_dead = 0;
        run_to_phase(P_RESPAWN, 0);
        repeat ($urandom_range(0, 5)) step();
        player_ack = 1; step(); player_ack = 0;
        run_to_phase(P_ALIVE, 0);

        // reset while waiting in RESPAWN
        player_dead = 1; step(); player_dead = 0;
        run_to_phase(P_RESPAWN, 0);
        repeat (5) step();
        reset = 1; step(); reset = 0;
        repeat (3) step();

        // free-running random traffic
        for (int i = 0; i < 4000; i++) begin
            reset      = ($urandom_range(0, 499) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) campfire_hit = !campfire_hit;
            if ($urandom_range(0, 3) == 0) begin
                campfire_id = 3'($urandom); campfire_x = 10'($urandom);
                campfire_y  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 20)) : 10'($urandom);
            end
            player_dead = ($urandom_range(0, 39) == 0);
            player_ack  = ($urandom_range(0, 7) == 0);
            step();
        end
        reset = 0; frame_tick = 0; campfire_hit = 0; player_dead = 0; player_ack = 0;
        step();

        @(negedge sim_clk);
        @(negedge sim_clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
